dmem_lsu: RTL and testbench

Load/store unit that sits between the processor datapath and the word-aligned data memory `dmem`, acting as the initiator of every `dmem` access. It accepts one byte, halfword or word load/store request at a time, drives `dmem`'s word address, write enable and write data, and extracts and extends read data. Sub-word stores become a two-cycle read-modify-write, because `dmem` only writes full words. Misaligned requests are rejected without touching memory.

---
 rtl/dmem_lsu.sv | 196 +++++++++++++++++++
 tb/tb_dmem_lsu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu
// Load/store unit between the processor datapath and the word-aligned data
// memory. It accepts one byte, halfword or word request at a time. Loads
// return a sign- or zero-extended lane of the addressed word. Word stores
// write directly. Sub-word stores read the word, merge the new lane in, and
// write the merged word back. Misaligned or illegal requests are answered
// with done+err and never touch memory.
//
// Ports
//   clk      rising-edge clock shared with dmem
//   reset_n  synchronous active-low reset
//   req      request strobe, sampled only while busy=0
//   wr       1=store, 0=load
//   size     00=byte, 01=half, 10=word, 11=illegal
//   uns      loads only: 1=zero-extend, 0=sign-extend
//   addr     byte address
//   wdata    right-justified store data
//   busy     request in flight (state != IDLE)
//   done     one-cycle completion pulse
//   err      one-cycle error pulse, coincident with done
//   rdata    extended load result, held until the next load completes
//   mem_a    word address to dmem (0 in IDLE)
//   mem_we   write enable to dmem
//   mem_wd   write data to dmem (0 when mem_we=0)
//   mem_rd   combinational read data from dmem
module dmem_lsu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RMW_RD = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  // Alignment is judged on the live request inputs at acceptance time.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction and extension for loads, little-endian lane order.
  always_comb begin
    ld_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    ld_ext  = mem_rd;
    case (size_q)
      SZ_BYTE: ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_rd;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane of the old word.
  always_comb begin
    merged = mem_rd;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state logic. done/err default low so they only ever pulse for one
  // cycle; a new request can be accepted in the cycle done is high because
  // the state is already back in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wr_d    = wr_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          wr_d    = wr;
          uns_d   = uns;
          wdata_d = wdata;
          if (misaligned) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (!wr) begin
            state_d = ST_LOAD;
          end else if (size == SZ_WORD) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = ld_ext;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RMW_RD: begin
        merge_d = merged;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single state register; reset aborts any in-flight request silently.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The write enable is gated by reset_n directly so that asserting reset in
  // the WRITE cycle prevents the memory write at that same edge.
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign mem_a  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_we = (state_q == ST_WRITE) && reset_n;
  assign mem_wd = mem_we ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu
// Directed bench for dmem_lsu. A 16-word behavioural dmem model is attached;
// each directed step drives a request and compares the unit's outputs and
// the model memory against hand-computed values.
module tb_dmem_lsu;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  dmem_lsu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .uns     (uns),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .mem_a   (mem_a),
    .mem_we  (mem_we),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: combinational read, write at the rising edge.
  assign mem_rd = mem[mem_a[5:2]];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present a request, let it be accepted at the next edge, then drop req.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req   = 1'b1;
    wr    = w;
    size  = sz;
    uns   = u;
    addr  = a;
    wdata = d;
    tick();
    req   = 1'b0;
    wdata = 32'hDEAD_BEEF;
    addr  = 32'hFFFF_FFFF;
  endtask

  // Load: LOAD cycle after acceptance, then done with rdata, then quiet.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, u, a, 32'h0);
    check1({tag, " load busy"}, busy, 1'b1);
    check1({tag, " load early done"}, done, 1'b0);
    check({tag, " load mem_a"}, mem_a, {a[31:2], 2'b00});
    check1({tag, " load mem_we"}, mem_we, 1'b0);
    tick();
    check1({tag, " load done"}, done, 1'b1);
    check1({tag, " load err"}, err, 1'b0);
    check1({tag, " load busy at done"}, busy, 1'b0);
    check({tag, " load rdata"}, rdata, exp);
    tick();
    check1({tag, " load done drop"}, done, 1'b0);
    check({tag, " load rdata held"}, rdata, exp);
  endtask

  // Sub-word store: read cycle, write cycle with merged word, then done.
  task automatic do_substore(input string tag, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] merged, input logic [31:0] keep_rdata);
    issue(1'b1, sz, 1'b0, a, d);
    check1({tag, " rmw rd busy"}, busy, 1'b1);
    check1({tag, " rmw rd mem_we"}, mem_we, 1'b0);
    check({tag, " rmw rd mem_wd"}, mem_wd, 32'h0);
    check({tag, " rmw rd mem_a"}, mem_a, {a[31:2], 2'b00});
    tick();
    check1({tag, " rmw wr mem_we"}, mem_we, 1'b1);
    check({tag, " rmw wr mem_wd"}, mem_wd, merged);
    check1({tag, " rmw wr done"}, done, 1'b0);
    tick();
    check1({tag, " rmw done"}, done, 1'b1);
    check1({tag, " rmw mem_we off"}, mem_we, 1'b0);
    check({tag, " rmw mem word"}, mem[a[5:2]], merged);
    check({tag, " rmw rdata untouched"}, rdata, keep_rdata);
    tick();
    check1({tag, " rmw done drop"}, done, 1'b0);
  endtask

  // Misaligned: done+err next cycle, no memory activity, rdata unchanged.
  task automatic do_misaligned(input string tag, input logic w, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] keep_rdata);
    issue(w, sz, 1'b0, a, 32'h1357_9BDF);
    check1({tag, " mis done"}, done, 1'b1);
    check1({tag, " mis err"}, err, 1'b1);
    check1({tag, " mis busy"}, busy, 1'b0);
    check1({tag, " mis mem_we"}, mem_we, 1'b0);
    check({tag, " mis rdata"}, rdata, keep_rdata);
    tick();
    check1({tag, " mis done drop"}, done, 1'b0);
    check1({tag, " mis err drop"}, err, 1'b0);
    check1({tag, " mis mem_we later"}, mem_we, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 1'b0;
    wr      = 1'b0;
    size    = 2'b00;
    uns     = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;

    // Reset held for two edges.
    tick();
    tick();
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset err", err, 1'b0);
    check1("reset mem_we", mem_we, 1'b0);
    check("reset rdata", rdata, 32'h0);
    check("reset mem_a", mem_a, 32'h0);
    check("reset mem_wd", mem_wd, 32'h0);
    reset_n = 1'b1;

    // Preload word 3 with a word store.
    issue(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h8899_AABB);
    check1("sw busy", busy, 1'b1);
    check1("sw mem_we", mem_we, 1'b1);
    check("sw mem_a", mem_a, 32'h0000_000C);
    check("sw mem_wd", mem_wd, 32'h8899_AABB);
    check1("sw early done", done, 1'b0);
    tick();
    check1("sw done", done, 1'b1);
    check1("sw mem_we once", mem_we, 1'b0);
    check1("sw busy at done", busy, 1'b0);
    check("sw mem word", mem[3], 32'h8899_AABB);
    check("sw rdata untouched", rdata, 32'h0);
    tick();
    check1("sw done drop", done, 1'b0);

    // Load extension across all lanes.
    do_load("lb",  2'b00, 1'b0, 32'h0000_000D, 32'hFFFF_FFAA);
    do_load("lbu", 2'b00, 1'b1, 32'h0000_000F, 32'h0000_0088);
    do_load("lh",  2'b01, 1'b0, 32'h0000_000E, 32'hFFFF_8899);
    do_load("lhu", 2'b01, 1'b1, 32'h0000_000C, 32'h0000_AABB);
    do_load("lw",  2'b10, 1'b0, 32'h0000_000C, 32'h8899_AABB);

    // Sub-word stores merged into word 3.
    do_substore("sb", 2'b00, 32'h0000_000D, 32'h1234_5677, 32'h8899_77BB, 32'h8899_AABB);
    do_substore("sh", 2'b01, 32'h0000_000E, 32'h0000_CAFE, 32'hCAFE_77BB, 32'h8899_AABB);

    // Misaligned and illegal requests.
    do_misaligned("lh 0x11", 1'b0, 2'b01, 32'h0000_0011, 32'h8899_AABB);
    do_misaligned("sw 0x0E", 1'b1, 2'b10, 32'h0000_000E, 32'h8899_AABB);
    do_misaligned("size11",  1'b0, 2'b11, 32'h0000_0010, 32'h8899_AABB);
    check("mis mem word3", mem[3], 32'hCAFE_77BB);
    check("mis mem word4", mem[4], 32'h1000_0004);

    // Request raised while busy must be ignored.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    req   = 1'b1;
    wr    = 1'b1;
    size  = 2'b10;
    addr  = 32'h0000_0000;
    wdata = 32'h0BAD_F00D;
    tick();
    req = 1'b0;
    check1("busy-ign done", done, 1'b1);
    check("busy-ign rdata", rdata, 32'hCAFE_77BB);
    tick();
    check1("busy-ign no extra done", done, 1'b0);
    check1("busy-ign not accepted", busy, 1'b0);
    check1("busy-ign no write", mem_we, 1'b0);
    check("busy-ign mem word0", mem[0], 32'h1000_0000);

    // Back-to-back: new lw issued in the done cycle of the previous one.
    issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    tick();
    check1("b2b first done", done, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    check1("b2b accepted", busy, 1'b1);
    check("b2b mem_a", mem_a, 32'h0000_0004);
    check1("b2b done gap", done, 1'b0);
    tick();
    check1("b2b second done", done, 1'b1);
    check("b2b rdata", rdata, 32'h1000_0001);
    tick();

    // Reset during the WRITE cycle of a byte store.
    issue(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_0055);
    tick();
    check1("rst-mid in write", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check1("rst-mid mem_we gated", mem_we, 1'b0);
    tick();
    check1("rst-mid busy", busy, 1'b0);
    check1("rst-mid done", done, 1'b0);
    check("rst-mid mem word", mem[3], 32'hCAFE_77BB);
    check("rst-mid rdata cleared", rdata, 32'h0);
    reset_n = 1'b1;
    tick();
    check1("rst-mid no late done", done, 1'b0);
    check1("rst-mid idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
